// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Measures one external PWM line. For every completed cycle it reports the
// high time and the full period in clk ticks, with a one-cycle strobe. If the
// line sits at one level for TIMEOUT cycles (0% or 100% duty), the block
// reports that once and raises a stuck flag.
//
// Optional build macro:
//   PWM_CAPTURE_GLITCH_FILTER_EN - adds a 2-of-3 majority filter after the
//   synchronizer. Single-cycle pulses and dropouts are rejected, and every
//   latency grows by one cycle.
//
// Parameters:
//   CNT_W    width of the measurement counters and result outputs
//   TIMEOUT  cycles without an edge before the stuck condition fires
//            (2 <= TIMEOUT <= 2^CNT_W-1)
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous reset, active low
//   pwm_in        asynchronous PWM line (synchronized internally)
//   high_cnt      high time of the last reported period
//   period_cnt    length of the last reported period
//   sample_valid  one-cycle strobe; high_cnt/period_cnt update with it
//   stuck_high    line has been high for TIMEOUT cycles
//   stuck_low     line has been low for TIMEOUT cycles
// -----------------------------------------------------------------------------
module pwm_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             sample_valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_STUCK = 2'd3
  } state_t;

  // Saturating increment: measurement counters stick at all-ones, never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ONE;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0/p1: two-flop synchronizer. vld_pN marks samples that were taken
  // after reset release, so reset values never look like a real line level.
  // ---------------------------------------------------------------------------
  logic sync_p0, sync_p1;
  logic vld_p0, vld_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      sync_p0 <= pwm_in;
      sync_p1 <= sync_p0;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Level selection: raw synchronizer output, or 2-of-3 majority of the last
  // three synchronized samples.
  // ---------------------------------------------------------------------------
  logic lvl;
  logic lvl_vld;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic hist_a_p1, hist_b_p1;
  logic vld_a_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_a_p1 <= 1'b0;
      hist_b_p1 <= 1'b0;
      vld_a_p1  <= 1'b0;
    end else begin
      hist_a_p1 <= sync_p1;
      hist_b_p1 <= hist_a_p1;
      vld_a_p1  <= vld_p1;
    end
  end

  assign lvl     = maj3(sync_p1, hist_a_p1, hist_b_p1);
  // Two real samples are enough to call the level: when they agree the
  // majority is settled regardless of the third, which keeps the post-reset
  // timeout latency at exactly one cycle more than the unfiltered build.
  assign lvl_vld = vld_a_p1;
`else
  assign lvl     = sync_p1;
  assign lvl_vld = vld_p1;
`endif

  // ---------------------------------------------------------------------------
  // Stage p2: edge detection. lvl_p2 is the line level for the cycle the FSM
  // is looking at; rise_p2/fall_p2 mark the first cycle of a new level. An
  // edge needs two real samples, so a line already high at reset release is
  // not mistaken for a rising edge.
  // ---------------------------------------------------------------------------
  logic lvl_p2, vld_p2, rise_p2, fall_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_p2  <= 1'b0;
      vld_p2  <= 1'b0;
      rise_p2 <= 1'b0;
      fall_p2 <= 1'b0;
    end else begin
      lvl_p2  <= lvl;
      vld_p2  <= lvl_vld;
      rise_p2 <= lvl_vld & vld_p2 &  lvl & ~lvl_p2;
      fall_p2 <= lvl_vld & vld_p2 & ~lvl &  lvl_p2;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p3: measurement FSM, counters and registered results.
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] h_cnt, h_nxt;
  logic [CNT_W-1:0] p_cnt, p_nxt;
  logic [CNT_W-1:0] idle_cnt, idle_nxt;
  logic [CNT_W-1:0] high_nxt, period_nxt;
  logic             vld_nxt, stk_h_nxt, stk_l_nxt;
  logic             edge_any;
  logic             tmo_hit;

  assign edge_any = rise_p2 | fall_p2;

  // An edge in the same cycle wins over the timeout: idle_cnt clears instead.
  // idle_cnt only advances once real samples reach this stage, so the timeout
  // after reset is measured from the first real line level.
  assign tmo_hit = ~edge_any & vld_p2 & (idle_cnt == TMO_M1) &
                   (state != ST_STUCK);

  always_comb begin
    state_nxt  = state;
    h_nxt      = h_cnt;
    p_nxt      = p_cnt;
    idle_nxt   = idle_cnt;
    vld_nxt    = 1'b0;
    high_nxt   = high_cnt;
    period_nxt = period_cnt;
    stk_h_nxt  = stuck_high;
    stk_l_nxt  = stuck_low;

    if (edge_any) begin
      idle_nxt = '0;
    end else if (vld_p2 && (idle_cnt != TMO)) begin
      idle_nxt = idle_cnt + ONE;
    end

    if (tmo_hit) begin
      state_nxt  = ST_STUCK;
      vld_nxt    = 1'b1;
      period_nxt = TMO;
      high_nxt   = lvl_p2 ? TMO : '0;
      stk_h_nxt  = lvl_p2;
      stk_l_nxt  = ~lvl_p2;
    end else begin
      case (state)
        ST_ARM: begin
          if (rise_p2) begin
            state_nxt = ST_HIGH;
            h_nxt     = ONE;
            p_nxt     = ONE;
          end
        end
        ST_HIGH: begin
          // The fall cycle is the first low cycle: it counts toward the
          // period but not the high time.
          p_nxt = sat_inc(p_cnt);
          if (fall_p2) begin
            state_nxt = ST_LOW;
          end else if (lvl_p2) begin
            h_nxt = sat_inc(h_cnt);
          end
        end
        ST_LOW: begin
          if (rise_p2) begin
            state_nxt  = ST_HIGH;
            vld_nxt    = 1'b1;
            high_nxt   = h_cnt;
            period_nxt = p_cnt;
            h_nxt      = ONE;
            p_nxt      = ONE;
          end else begin
            p_nxt = sat_inc(p_cnt);
          end
        end
        ST_STUCK: begin
          if (rise_p2) begin
            state_nxt = ST_HIGH;
            h_nxt     = ONE;
            p_nxt     = ONE;
            stk_h_nxt = 1'b0;
            stk_l_nxt = 1'b0;
          end else if (fall_p2) begin
            // High time before this fall is unknown: re-arm without a report.
            state_nxt = ST_ARM;
            stk_h_nxt = 1'b0;
            stk_l_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = ST_ARM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_ARM;
      h_cnt        <= '0;
      p_cnt        <= '0;
      idle_cnt     <= '0;
      sample_valid <= 1'b0;
      high_cnt     <= '0;
      period_cnt   <= '0;
      stuck_high   <= 1'b0;
      stuck_low    <= 1'b0;
    end else begin
      state        <= state_nxt;
      h_cnt        <= h_nxt;
      p_cnt        <= p_nxt;
      idle_cnt     <= idle_nxt;
      sample_valid <= vld_nxt;
      high_cnt     <= high_nxt;
      period_cnt   <= period_nxt;
      stuck_high   <= stk_h_nxt;
      stuck_low    <= stk_l_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Bench for pwm_capture with CNT_W=8. The main instance uses TIMEOUT=64; a
// second instance with TIMEOUT=255 shares the stimulus and is only examined
// for the counter saturation case. Every strobe of either instance is logged
// with the cycle number it appeared on; sequences then compare the log with
// values derived from the driven phase lengths.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

  localparam int TMO     = 64;
  localparam int CNT_MAX = 255;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT  = 4;
  localparam int MINP = 2;
`else
  localparam int LAT  = 3;
  localparam int MINP = 1;
`endif

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] high_cnt, period_cnt;
  logic       sample_valid, stuck_high, stuck_low;
  logic [7:0] s_high_cnt, s_period_cnt;
  logic       s_sample_valid, s_stuck_high, s_stuck_low;

  pwm_capture #(.CNT_W(8), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .high_cnt     (high_cnt),
    .period_cnt   (period_cnt),
    .sample_valid (sample_valid),
    .stuck_high   (stuck_high),
    .stuck_low    (stuck_low)
  );

  pwm_capture #(.CNT_W(8), .TIMEOUT(255)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .high_cnt     (s_high_cnt),
    .period_cnt   (s_period_cnt),
    .sample_valid (s_sample_valid),
    .stuck_high   (s_stuck_high),
    .stuck_low    (s_stuck_low)
  );

  always #5 clk = ~clk;

  // cyc is the index of the pin sample taken by the most recent rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int hi;
    int per;
    int sh;
    int sl;
  } strobe_t;

  strobe_t cap_q[$];
  strobe_t sat_q[$];

  function automatic strobe_t mk_s(input int c, input logic [7:0] h,
                                   input logic [7:0] p, input logic a,
                                   input logic b);
    strobe_t s;
    s.cyc = c;
    s.hi  = int'(h);
    s.per = int'(p);
    s.sh  = int'(a);
    s.sl  = int'(b);
    return s;
  endfunction

  always @(negedge clk) begin
    if (sample_valid)   cap_q.push_back(mk_s(cyc, high_cnt, period_cnt, stuck_high, stuck_low));
    if (s_sample_valid) sat_q.push_back(mk_s(cyc, s_high_cnt, s_period_cnt, s_stuck_high, s_stuck_low));
  end

  int checks   = 0;
  int failures = 0;
  int rel_cyc  = 0;
  int rise_q[$];
  int ph_h[$];
  int ph_l[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic exp_s(input string nm, input int idx, input int c, input int hi,
                       input int per, input int sh, input int sl);
    if (idx >= cap_q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s: strobe %0d missing, got %0d strobes", nm, idx, cap_q.size());
    end else begin
      chk({nm, "_cycle"},  cap_q[idx].cyc, c);
      chk({nm, "_high"},   cap_q[idx].hi,  hi);
      chk({nm, "_period"}, cap_q[idx].per, per);
      chk({nm, "_sthigh"}, cap_q[idx].sh,  sh);
      chk({nm, "_stlow"},  cap_q[idx].sl,  sl);
    end
  endtask

  // Drive one pin value; it is sampled by the next rising edge, and on return
  // cyc holds that sample's index.
  task automatic tick(input logic v);
    pwm_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic do_reset(input logic line);
    rst    = 1'b0;
    pwm_in = line;
    #1;
    chk("rst_valid",  int'(sample_valid), 0);
    chk("rst_high",   int'(high_cnt),     0);
    chk("rst_period", int'(period_cnt),   0);
    chk("rst_sthigh", int'(stuck_high),   0);
    chk("rst_stlow",  int'(stuck_low),    0);
    hold(line, 3);
    rst = 1'b1;
    rel_cyc = cyc;
    cap_q.delete();
    sat_q.delete();
  endtask

  // Play ph_h/ph_l as complete periods, then one closing rise.
  task automatic play();
    rise_q.delete();
    hold(1'b0, 4);
    for (int i = 0; i < ph_h.size(); i++) begin
      tick(1'b1);
      rise_q.push_back(cyc);
      hold(1'b1, ph_h[i] - 1);
      hold(1'b0, ph_l[i]);
    end
    tick(1'b1);
    rise_q.push_back(cyc);
    hold(1'b1, LAT + 3);
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  typedef struct {
    int h;
    int l;
    int exp_hi;
    int exp_per;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input int h, input int l, input int eh, input int ep);
    vec_t v;
    v.h = h; v.l = l; v.exp_hi = eh; v.exp_per = ep;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, rg, r3, r4, ra, rb, n;

    vecs.push_back(mkv(3, 5, 3, 8));
    vecs.push_back(mkv(2, 2, 2, 4));
    vecs.push_back(mkv(10, 4, 10, 14));
    vecs.push_back(mkv(40, 23, 40, 63));
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    vecs.push_back(mkv(1, 6, 1, 7));
    vecs.push_back(mkv(5, 1, 5, 6));
`endif

    @(posedge clk);
    #1;

    // Table: steady streams, three periods each.
    foreach (vecs[k]) begin
      do_reset(1'b0);
      ph_h.delete();
      ph_l.delete();
      for (int i = 0; i < 3; i++) begin
        ph_h.push_back(vecs[k].h);
        ph_l.push_back(vecs[k].l);
      end
      play();
      chk($sformatf("vec%0d_count", k), cap_q.size(), 3);
      for (int i = 0; i < 3; i++)
        exp_s($sformatf("vec%0d_s%0d", k, i), i, rise_q[i + 1] + LAT,
              vecs[k].exp_hi, vecs[k].exp_per, 0, 0);
    end

    // Random phase streams against the phase-length model.
    for (int rr = 0; rr < 3; rr++) begin
      do_reset(1'b0);
      ph_h.delete();
      ph_l.delete();
      n = 12;
      for (int i = 0; i < n; i++) begin
        ph_h.push_back($urandom_range(30, MINP));
        ph_l.push_back($urandom_range(30, MINP));
      end
      play();
      chk($sformatf("rnd%0d_count", rr), cap_q.size(), n);
      for (int i = 0; i < n; i++)
        exp_s($sformatf("rnd%0d_s%0d", rr, i), i, rise_q[i + 1] + LAT,
              sat(ph_h[i]), sat(ph_h[i] + ph_l[i]), 0, 0);
    end

    // Line held low from reset: one stuck-low report, then silence.
    do_reset(1'b0);
    hold(1'b0, 150);
    chk("stk0_count", cap_q.size(), 1);
    exp_s("stk0", 0, rel_cyc + TMO + LAT, 0, TMO, 0, 1);
    chk("stk0_flag", int'(stuck_low), 1);
    tick(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 5);
    chk("stk0_clear", int'(stuck_low), 0);
    tick(1'b1);
    r2 = cyc;
    hold(1'b1, LAT + 2);
    chk("stk0_after_count", cap_q.size(), 2);
    exp_s("stk0_after", 1, r2 + LAT, 3, 8, 0, 0);

    // Line held high for 100 cycles mid-stream.
    do_reset(1'b0);
    hold(1'b0, 4);
    tick(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    r = cyc;
    hold(1'b1, 99);
    chk("stk1_flag", int'(stuck_high), 1);
    hold(1'b0, 5);
    chk("stk1_clear", int'(stuck_high), 0);
    tick(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    r2 = cyc;
    hold(1'b1, LAT + 2);
    chk("stk1_count", cap_q.size(), 3);
    exp_s("stk1_pre",  0, r + LAT, 3, 8, 0, 0);
    exp_s("stk1_tmo",  1, r + LAT + TMO, TMO, TMO, 1, 0);
    exp_s("stk1_post", 2, r2 + LAT, 3, 8, 0, 0);

    // Period counter saturation on the TIMEOUT=255 instance.
    do_reset(1'b0);
    hold(1'b0, 4);
    tick(1'b1);
    hold(1'b1, 199);
    hold(1'b0, 100);
    tick(1'b1);
    r = cyc;
    hold(1'b1, LAT + 2);
    chk("sat_count", sat_q.size(), 1);
    if (sat_q.size() > 0) begin
      chk("sat_cycle",  sat_q[0].cyc, r + LAT);
      chk("sat_high",   sat_q[0].hi,  200);
      chk("sat_period", sat_q[0].per, 255);
    end

    // Asynchronous reset in the middle of a high phase.
    do_reset(1'b0);
    hold(1'b0, 4);
    tick(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    hold(1'b1, 1);
    chk("mid_pre_high",   int'(high_cnt),   3);
    chk("mid_pre_period", int'(period_cnt), 8);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_high",   int'(high_cnt),     0);
    chk("mid_rst_period", int'(period_cnt),   0);
    chk("mid_rst_valid",  int'(sample_valid), 0);
    @(posedge clk);
    #1;
    hold(1'b1, 1);
    rst = 1'b1;
    cap_q.delete();
    hold(1'b1, 1);
    hold(1'b0, 5);
    tick(1'b1);
    ra = cyc;
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    rb = cyc;
    hold(1'b1, LAT + 2);
    chk("mid_count", cap_q.size(), 1);
    exp_s("mid_first", 0, rb + LAT, 3, 8, 0, 0);
    chk("mid_rise_gap", rb - ra, 8);

    // One-cycle glitch inside the low phase of an H=3, L=5 stream.
    do_reset(1'b0);
    hold(1'b0, 4);
    tick(1'b1);
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    r2 = cyc;
    hold(1'b1, 2);
    hold(1'b0, 2);
    tick(1'b1);
    rg = cyc;
    hold(1'b0, 2);
    tick(1'b1);
    r3 = cyc;
    hold(1'b1, 2);
    hold(1'b0, 5);
    tick(1'b1);
    r4 = cyc;
    hold(1'b1, LAT + 2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    chk("gl_count", cap_q.size(), 3);
    exp_s("gl_a", 0, r2 + LAT, 3, 8, 0, 0);
    exp_s("gl_b", 1, r3 + LAT, 3, 8, 0, 0);
    exp_s("gl_c", 2, r4 + LAT, 3, 8, 0, 0);
    chk("gl_rg_unused", rg - r2, 5);
`else
    chk("gl_count", cap_q.size(), 4);
    exp_s("gl_a", 0, r2 + LAT, 3, 8, 0, 0);
    exp_s("gl_b", 1, rg + LAT, 3, 5, 0, 0);
    exp_s("gl_c", 2, r3 + LAT, 1, 3, 0, 0);
    exp_s("gl_d", 3, r4 + LAT, 3, 8, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
